// File: rtl/vga_timing_pkg.sv
// Shared constants and state types for the 640x480@60 Hz VGA raster sequencer.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int PIX_DIV = 4;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {ST_H_ACT, ST_H_FP, ST_H_SYNC, ST_H_BP} h_state_t;
  typedef enum logic [1:0] {ST_V_ACT, ST_V_FP, ST_V_SYNC, ST_V_BP} v_state_t;

endpackage

// File: rtl/vga_timing_pix_tick_gen.sv
// Pixel-rate enable: one-clk tick every DIV system clocks; counter frozen while disabled.
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] CNT_LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  assign tick = enable && (div_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: horizontal/vertical phase FSMs with registered sync, blanking and x/y.
//   state     | meaning
//   ST_H_ACT  | visible pixels of a line
//   ST_H_FP   | horizontal front porch
//   ST_H_SYNC | hsync asserted
//   ST_H_BP   | horizontal back porch (reset state, next tick wraps x to 0)
//   ST_V_*    | same phases per line, advancing only when x wraps
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int DIV      = PIX_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

  h_state_t         h_state, h_state_nxt;
  v_state_t         v_state, v_state_nxt;
  logic [CNT_W-1:0] h_cnt, h_cnt_nxt;
  logic [CNT_W-1:0] v_cnt, v_cnt_nxt;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             line_wrap;

  pix_tick_gen #(.DIV(DIV)) u_pix_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (pix_tick)
  );

  assign line_wrap = pix_tick && (x == X_LAST);

  // Phase counters count down; reaching zero on a tick ends the phase.
  always_comb begin
    h_state_nxt = h_state;
    h_cnt_nxt   = h_cnt;
    if (pix_tick) begin
      if (h_cnt == '0) begin
        case (h_state)
          ST_H_ACT:  begin h_state_nxt = ST_H_FP;   h_cnt_nxt = CNT_W'(H_FP - 1);     end
          ST_H_FP:   begin h_state_nxt = ST_H_SYNC; h_cnt_nxt = CNT_W'(H_SYNC - 1);   end
          ST_H_SYNC: begin h_state_nxt = ST_H_BP;   h_cnt_nxt = CNT_W'(H_BP - 1);     end
          default:   begin h_state_nxt = ST_H_ACT;  h_cnt_nxt = CNT_W'(H_ACTIVE - 1); end
        endcase
      end else begin
        h_cnt_nxt = h_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    v_state_nxt = v_state;
    v_cnt_nxt   = v_cnt;
    if (line_wrap) begin
      if (v_cnt == '0) begin
        case (v_state)
          ST_V_ACT:  begin v_state_nxt = ST_V_FP;   v_cnt_nxt = CNT_W'(V_FP - 1);     end
          ST_V_FP:   begin v_state_nxt = ST_V_SYNC; v_cnt_nxt = CNT_W'(V_SYNC - 1);   end
          ST_V_SYNC: begin v_state_nxt = ST_V_BP;   v_cnt_nxt = CNT_W'(V_BP - 1);     end
          default:   begin v_state_nxt = ST_V_ACT;  v_cnt_nxt = CNT_W'(V_ACTIVE - 1); end
        endcase
      end else begin
        v_cnt_nxt = v_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (pix_tick) begin
      x_nxt = (x == X_LAST) ? '0 : x + 1'b1;
      if (line_wrap) begin
        y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
      end
    end
  end

  // Outputs decode the next state so they line up with the x/y registered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_state     <= ST_H_BP;
      h_cnt       <= '0;
      v_state     <= ST_V_BP;
      v_cnt       <= '0;
      x           <= X_LAST;
      y           <= Y_LAST;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_state     <= h_state_nxt;
      h_cnt       <= h_cnt_nxt;
      v_state     <= v_state_nxt;
      v_cnt       <= v_cnt_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      video_on    <= (h_state_nxt == ST_H_ACT) && (v_state_nxt == ST_V_ACT);
      hsync       <= (h_state_nxt == ST_H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_state_nxt == ST_V_SYNC) ? SYNC_POL : ~SYNC_POL;
      line_end    <= pix_tick && (x_nxt == X_LAST);
      frame_start <= pix_tick && (x_nxt == '0) && (y_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-width lines, short vertical phases so whole frames fit in the run.
module tb_vga_timing_ctrl;

  localparam int DIV = 4;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pix_tick, hsync, vsync, video_on, line_end, frame_start;
  logic [9:0] x, y;

  int tests = 0;
  int fails = 0;

  int m_div = 0, m_x = HT - 1, m_y = VT - 1;
  bit m_le = 1'b0, m_fs = 1'b0;

  vga_timing_ctrl #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(pix_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
    .line_end(line_end), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Raster reference: position advances one pixel per DIV enabled clocks.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_div = 0; m_x = HT - 1; m_y = VT - 1; m_le = 0; m_fs = 0;
    end else if (enable && m_div == DIV - 1) begin
      m_div = 0;
      if (m_x == HT - 1) begin
        m_x = 0;
        m_y = (m_y + 1) % VT;
      end else begin
        m_x = m_x + 1;
      end
      m_le = (m_x == HT - 1);
      m_fs = (m_x == 0) && (m_y == 0);
    end else begin
      if (enable) m_div = m_div + 1;
      m_le = 0; m_fs = 0;
    end
    #1;
  endtask

  function automatic logic [25:0] obs_vec();
    return {pix_tick, hsync, vsync, video_on, x, y, line_end, frame_start};
  endfunction

  function automatic logic [25:0] model_vec();
    logic tk, hs, vs, vo;
    logic [9:0] mx, my;
    tk = enable && (m_div == DIV - 1);
    hs = !(m_x >= HA + HF && m_x < HA + HF + HS);
    vs = !(m_y >= VA + VF && m_y < VA + VF + VS);
    vo = (m_x < HA) && (m_y < VA);
    mx = 10'(m_x);
    my = 10'(m_y);
    return {tk, hs, vs, vo, mx, my, m_le, m_fs};
  endfunction

  task automatic test_reset();
    int n;
    reset = 1; enable = 1;
    repeat (5) begin
      step();
      tests++;
      if (x !== 10'(HT - 1) || y !== 10'(VT - 1) || video_on !== 1'b0 || hsync !== 1'b1 ||
          vsync !== 1'b1 || {pix_tick, line_end, frame_start} !== 3'b000) begin
        fails++;
        $display("FAIL reset_values: got x=%0d y=%0d vo=%b hs=%b vs=%b pulses=%b, want x=%0d y=%0d vo=0 hs=1 vs=1 pulses=000",
                 x, y, video_on, hsync, vsync, {pix_tick, line_end, frame_start}, HT - 1, VT - 1);
      end
    end
    reset = 0;
    n = 0;
    while (frame_start !== 1'b1 && n < 20) begin
      step(); n++;
      tests++;
      if (obs_vec() !== model_vec()) begin
        fails++;
        $display("FAIL startup_cycle %0d: got %h want %h", n, obs_vec(), model_vec());
      end
    end
    tests++;
    if (n !== DIV) begin
      fails++;
      $display("FAIL first_frame_start: got after %0d clks, want %0d", n, DIV);
    end
    tests++;
    if (x !== 10'd0 || y !== 10'd0 || video_on !== 1'b1) begin
      fails++;
      $display("FAIL first_pixel: got x=%0d y=%0d vo=%b, want 0 0 1", x, y, video_on);
    end
  endtask

  task automatic test_free_run();
    int n = 0, last_tick = -1, last_le = -1, hs_run = 0, vs_run = 0;
    int hs_min = 1023, hs_max = -1, vo_clks = 0;
    bit seen = 0;
    enable = 1;
    while (!seen && n < FRAME_CLKS + 8) begin
      step(); n++;
      tests++;
      if (obs_vec() !== model_vec()) begin
        fails++;
        $display("FAIL free_run clk %0d: got %h want %h", n, obs_vec(), model_vec());
      end
      if (pix_tick === 1'b1) begin
        if (last_tick >= 0) begin
          tests++;
          if (n - last_tick !== DIV) begin
            fails++;
            $display("FAIL tick_period: got %0d want %0d", n - last_tick, DIV);
          end
        end
        last_tick = n;
      end
      if (line_end === 1'b1) begin
        if (last_le >= 0) begin
          tests++;
          if (n - last_le !== HT * DIV) begin
            fails++;
            $display("FAIL line_period: got %0d want %0d", n - last_le, HT * DIV);
          end
        end
        last_le = n;
      end
      if (hsync === 1'b0) begin
        hs_run++;
        if (y == 0) begin
          if (int'(x) < hs_min) hs_min = int'(x);
          if (int'(x) > hs_max) hs_max = int'(x);
        end
      end else if (hs_run != 0) begin
        tests++;
        if (hs_run !== HS * DIV) begin
          fails++;
          $display("FAIL hsync_width: got %0d want %0d", hs_run, HS * DIV);
        end
        hs_run = 0;
      end
      if (vsync === 1'b0) vs_run++;
      else if (vs_run != 0) begin
        tests++;
        if (vs_run !== VS * HT * DIV) begin
          fails++;
          $display("FAIL vsync_width: got %0d want %0d", vs_run, VS * HT * DIV);
        end
        vs_run = 0;
      end
      if (video_on === 1'b1 && y == 0) vo_clks++;
      if (frame_start === 1'b1) seen = 1;
    end
    tests++;
    if (n !== FRAME_CLKS) begin
      fails++;
      $display("FAIL frame_period: got %0d want %0d", n, FRAME_CLKS);
    end
    tests++;
    if (hs_min !== HA + HF || hs_max !== HA + HF + HS - 1) begin
      fails++;
      $display("FAIL hsync_x_range: got %0d..%0d want %0d..%0d", hs_min, hs_max, HA + HF, HA + HF + HS - 1);
    end
    tests++;
    if (vo_clks !== HA * DIV) begin
      fails++;
      $display("FAIL video_on_line: got %0d want %0d", vo_clks, HA * DIV);
    end
  endtask

  task automatic test_pause();
    int n = 0, held_div;
    logic [24:0] snap;
    enable = 1;
    while (x !== 10'd300 && n < 4000) begin step(); n++; end
    tests++;
    if (x !== 10'd300) begin
      fails++;
      $display("FAIL pause_reach: got x=%0d want 300", x);
    end
    repeat ($urandom_range(0, DIV - 2)) step();
    snap = {hsync, vsync, video_on, x, y, line_end, frame_start};
    held_div = m_div;
    enable = 0;
    repeat (37) begin
      step();
      tests++;
      if ({hsync, vsync, video_on, x, y, line_end, frame_start} !== snap || pix_tick !== 1'b0) begin
        fails++;
        $display("FAIL pause_hold: got %h tick=%b want %h tick=0",
                 {hsync, vsync, video_on, x, y, line_end, frame_start}, pix_tick, snap);
      end
    end
    enable = 1;
    n = 0;
    while (x !== 10'd301 && n < 20) begin step(); n++; end
    tests++;
    if (n !== DIV - held_div) begin
      fails++;
      $display("FAIL pause_resume: got x=301 after %0d clks, want %0d", n, DIV - held_div);
    end
    tests++;
    if (obs_vec() !== model_vec()) begin
      fails++;
      $display("FAIL pause_model: got %h want %h", obs_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    enable = 1;
    while (!(x === 10'd700 && y === 10'(VA + VF)) && n < 40000) begin step(); n++; end
    tests++;
    if (vsync !== 1'b0 || x !== 10'd700) begin
      fails++;
      $display("FAIL mid_reach: got x=%0d y=%0d vs=%b want 700 %0d 0", x, y, vsync, VA + VF);
    end
    reset = 1;
    step();
    tests++;
    if (x !== 10'(HT - 1) || y !== 10'(VT - 1) || vsync !== 1'b1 || hsync !== 1'b1 ||
        video_on !== 1'b0 || {pix_tick, line_end, frame_start} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset_values: got x=%0d y=%0d vs=%b hs=%b vo=%b pulses=%b",
               x, y, vsync, hsync, video_on, {pix_tick, line_end, frame_start});
    end
    reset = 0;
    n = 0;
    while (frame_start !== 1'b1 && n < 20) begin step(); n++; end
    tests++;
    if (n !== DIV || x !== 10'd0 || y !== 10'd0) begin
      fails++;
      $display("FAIL mid_restart: got fs after %0d clks at (%0d,%0d), want %0d at (0,0)", n, x, y, DIV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 299) == 0);
      step();
      tests++;
      if (obs_vec() !== model_vec()) begin
        fails++;
        $display("FAIL random clk %0d: got %h want %h", i, obs_vec(), model_vec());
      end
    end
    reset = 0; enable = 1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pause();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
